// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter in front of the single-port data memory.
// Port 0 is the CPU and port 1 is the host/loader. Each access runs
// IDLE -> ISSUE -> ACK, so it takes three cycles. Every output is registered.
// The read word is captured at the ISSUE->ACK edge, so it is valid together
// with the ack pulse. The memory must therefore present read data by the
// end of the strobe cycle.
// Optional feature: define DMARB_FIXPRI_EN for fixed priority, where port 0
// always wins a tie. The default build uses round-robin arbitration.
module dmem_arbiter #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              gnt,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    ACK   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                ack0_q, ack0_d;
  logic                ack1_q, ack1_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d;
  logic [DATA_W-1:0]   rdata1_q, rdata1_d;
  logic                gnt_q, gnt_d;
  logic                busy_q, busy_d;
  logic                last_q, last_d;
  logic                win_c;

  // Winner selection among the currently raised requests
  always_comb begin
    win_c = 1'b0;
    if (req0 && req1) begin
`ifdef DMARB_FIXPRI_EN
      win_c = 1'b0;
`else
      win_c = ~last_q;
`endif
    end else if (req1) begin
      win_c = 1'b1;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    mem_en_d    = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    gnt_d       = gnt_q;
    last_d      = last_q;

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d     = ISSUE;
          gnt_d       = win_c;
          mem_en_d    = 1'b1;
          mem_we_d    = win_c ? we1 : we0;
          mem_addr_d  = win_c ? addr1 : addr0;
          mem_wdata_d = win_c ? wdata1 : wdata0;
        end
      end
      ISSUE: begin
        // Strobe ends here; read data is captured as the ack is raised
        state_d  = ACK;
        mem_we_d = 1'b0;
        if (gnt_q) begin
          ack1_d = 1'b1;
          if (!mem_we_q) rdata1_d = mem_rdata;
        end else begin
          ack0_d = 1'b1;
          if (!mem_we_q) rdata0_d = mem_rdata;
        end
      end
      ACK: begin
        // The acked port's req is not sampled here, only in the next IDLE
        state_d = IDLE;
        last_d  = gnt_q;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      gnt_q       <= 1'b0;
      busy_q      <= 1'b0;
      last_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      gnt_q       <= gnt_d;
      busy_q      <= busy_d;
      last_q      <= last_d;
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign gnt       = gnt_q;
  assign busy      = busy_q;

endmodule
